// File: rtl/stall_ctrl_pkg.sv
// Shared encodings and constants for the pipeline stall controller.
package stall_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE       = 2'd3;
    localparam int         MULT_CYCLES_DEF = 5;
    localparam int         DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // A source register stalls when a younger-stage producer will not have it ready in time.
    function automatic logic reg_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] a3_e,
        input logic [1:0] tnew_e,
        input logic [4:0] a3_m,
        input logic [1:0] tnew_m
    );
        logic hit_e;
        logic hit_m;
        hit_e = (src == a3_e) && (tnew_e > tuse);
        hit_m = (src == a3_m) && (tnew_m > tuse);
        return (src != 5'd0) && (hit_e || hit_m);
    endfunction

endpackage

// File: rtl/stall_ctrl_md_busy_timer.sv
// HI/LO unit busy timer: loads the unit latency on a start and counts down to idle.
module md_busy_timer
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic mult_start,
    input  logic div_start,
    output logic busy
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    md_state_e         state_q;
    md_state_e         state_d;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              busy_q;

    // Next-state logic; a start in either state (re)loads the count, div winning over mult.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            MD_IDLE: begin
                if (div_start) begin
                    count_d = CW'(DIV_CYCLES);
                    state_d = MD_BUSY;
                end else if (mult_start) begin
                    count_d = CW'(MULT_CYCLES);
                    state_d = MD_BUSY;
                end else begin
                    count_d = {CW{1'b0}};
                    state_d = MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (div_start) begin
                    count_d = CW'(DIV_CYCLES);
                end else if (mult_start) begin
                    count_d = CW'(MULT_CYCLES);
                end else begin
                    count_d = count_q - CW'(1);
                end
                if (count_d == {CW{1'b0}}) begin
                    state_d = MD_IDLE;
                end else begin
                    state_d = MD_BUSY;
                end
            end
            default: begin
                count_d = {CW{1'b0}};
                state_d = MD_IDLE;
            end
        endcase
    end

    // State, count and busy flag registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            count_q <= {CW{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= (count_d != {CW{1'b0}});
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline hazard/stall controller: data and HI/LO hazards, PC/F-D hold, D->E bubble, stall counter.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [1:0]       tuse_rs_D,
    input  logic [1:0]       tuse_rt_D,
    input  logic             md_use_D,
    input  logic [4:0]       a3_E,
    input  logic [1:0]       tnew_E,
    input  logic [4:0]       a3_M,
    input  logic [1:0]       tnew_M,
    input  logic             mult_start_E,
    input  logic             div_start_E,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic             ir_d_en,
    output logic             e_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             stall_rs_s;
    logic             stall_rt_s;
    logic             stall_md_s;
    logic             stall_s;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_timer (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start_E),
        .div_start  (div_start_E),
        .busy       (md_busy)
    );

    assign stall_rs_s = reg_hazard(rs_D, tuse_rs_D, a3_E, tnew_E, a3_M, tnew_M);
    assign stall_rt_s = reg_hazard(rt_D, tuse_rt_D, a3_E, tnew_E, a3_M, tnew_M);
    // A start in E is counted as busy already, since the timer only sees it next cycle.
    assign stall_md_s = md_use_D && (md_busy || mult_start_E || div_start_E);
    assign stall_s    = stall_rs_s | stall_rt_s | stall_md_s;

    assign pc_en   = ~stall_s;
    assign ir_d_en = ~stall_s;
    assign e_flush = stall_s;

    // Saturating stall counter; clear wins over increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = {CNT_W{1'b0}};
        end else if (stall_s && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: hazards, HI/LO timer, reset abort and stall counter.
module tb_stall_ctrl;
    import stall_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_D;
    logic [4:0]  rt_D;
    logic [1:0]  tuse_rs_D;
    logic [1:0]  tuse_rt_D;
    logic        md_use_D;
    logic [4:0]  a3_E;
    logic [1:0]  tnew_E;
    logic [4:0]  a3_M;
    logic [1:0]  tnew_M;
    logic        mult_start_E;
    logic        div_start_E;
    logic        cnt_clr;
    logic        pc_en;
    logic        ir_d_en;
    logic        e_flush;
    logic        md_busy;
    logic [31:0] stall_cnt;
    logic        pc_en2;
    logic        ir_d_en2;
    logic        e_flush2;
    logic        md_busy2;
    logic [1:0]  stall_cnt2;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    stall_ctrl dut (
        .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D),
        .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .md_use_D(md_use_D),
        .a3_E(a3_E), .tnew_E(tnew_E), .a3_M(a3_M), .tnew_M(tnew_M),
        .mult_start_E(mult_start_E), .div_start_E(div_start_E), .cnt_clr(cnt_clr),
        .pc_en(pc_en), .ir_d_en(ir_d_en), .e_flush(e_flush),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    stall_ctrl #(.CNT_W(2)) dut_w2 (
        .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D),
        .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .md_use_D(md_use_D),
        .a3_E(a3_E), .tnew_E(tnew_E), .a3_M(a3_M), .tnew_M(tnew_M),
        .mult_start_E(mult_start_E), .div_start_E(div_start_E), .cnt_clr(cnt_clr),
        .pc_en(pc_en2), .ir_d_en(ir_d_en2), .e_flush(e_flush2),
        .md_busy(md_busy2), .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, "_flush"}, {31'd0, e_flush}, {31'd0, exp});
        chk({tag, "_pc_en"}, {31'd0, pc_en}, {31'd0, ~exp});
        chk({tag, "_ir_en"}, {31'd0, ir_d_en}, {31'd0, ~exp});
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs_D = 5'd0; rt_D = 5'd0;
        tuse_rs_D = TUSE_NONE; tuse_rt_D = TUSE_NONE;
        md_use_D = 1'b0;
        a3_E = 5'd0; tnew_E = 2'd0; a3_M = 5'd0; tnew_M = 2'd0;
        mult_start_E = 1'b0; div_start_E = 1'b0; cnt_clr = 1'b0;
    endtask

    initial begin
        // 1. reset and idle outputs
        idle_inputs();
        reset = 1'b0;
        #2;
        chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        #2;
        chk_stall("idle", 1'b0);
        chk("idle_md_busy", {31'd0, md_busy}, 32'd0);
        chk("idle_cnt", stall_cnt, 32'd0);

        // 2. data hazards
        rs_D = 5'd8; tuse_rs_D = 2'd0; a3_E = 5'd8; tnew_E = 2'd1;
        #1;
        chk_stall("rs_e_hz", 1'b1);
        rs_D = 5'd0;
        #1;
        chk_stall("rs_zero", 1'b0);
        rs_D = 5'd8; a3_E = 5'd0; tnew_E = 2'd0;
        a3_M = 5'd8; tnew_M = 2'd1; tuse_rs_D = 2'd1;
        #1;
        chk_stall("rs_m_eq", 1'b0);
        idle_inputs();
        rt_D = 5'd9; tuse_rt_D = 2'd1; a3_M = 5'd9; tnew_M = 2'd2;
        #1;
        chk_stall("rt_m_hz", 1'b1);
        tuse_rt_D = TUSE_NONE;
        #1;
        chk_stall("rt_unused", 1'b0);
        idle_inputs();

        // 3. div latency and md stall
        tick();
        div_start_E = 1'b1; md_use_D = 1'b1;
        #2;
        chk("div_t_busy", {31'd0, md_busy}, 32'd0);
        chk("div_t_flush", {31'd0, e_flush}, 32'd1);
        tick();
        div_start_E = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            #2;
            chk($sformatf("div_busy_t%0d", k), {31'd0, md_busy}, 32'd1);
            chk($sformatf("div_flush_t%0d", k), {31'd0, e_flush}, 32'd1);
            tick();
        end
        #2;
        chk("div_t11_busy", {31'd0, md_busy}, 32'd0);
        chk("div_t11_flush", {31'd0, e_flush}, 32'd0);
        md_use_D = 1'b0;

        // 4. mult at t, div at t+2 reloads
        tick();
        mult_start_E = 1'b1;
        tick();
        mult_start_E = 1'b0;
        #2;
        chk("mul_t1_busy", {31'd0, md_busy}, 32'd1);
        tick();
        div_start_E = 1'b1;
        tick();
        div_start_E = 1'b0;
        for (int k = 3; k < 12; k++) tick();
        #2;
        chk("rld_t12_busy", {31'd0, md_busy}, 32'd1);
        tick();
        #2;
        chk("rld_t13_busy", {31'd0, md_busy}, 32'd0);

        // 5. reset aborts a div
        tick();
        div_start_E = 1'b1;
        tick();
        div_start_E = 1'b0;
        tick();
        tick();
        #2;
        chk("abort_pre_busy", {31'd0, md_busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, md_busy}, 32'd0);
        chk("abort_cnt", stall_cnt, 32'd0);
        tick();
        reset = 1'b1;
        md_use_D = 1'b1;
        #2;
        chk("post_rst_flush", {31'd0, e_flush}, 32'd0);
        md_use_D = 1'b0;

        // 6. stall counter
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        rs_D = 5'd8; tuse_rs_D = 2'd0; a3_E = 5'd8; tnew_E = 2'd1;
        tick();
        tick();
        tick();
        idle_inputs();
        #2;
        chk("cnt3", stall_cnt, 32'd3);
        chk("cnt3_w2", {30'd0, stall_cnt2}, 32'd3);
        tick();
        rs_D = 5'd8; tuse_rs_D = 2'd0; a3_E = 5'd8; tnew_E = 2'd1;
        tick();
        tick();
        idle_inputs();
        #2;
        chk("cnt5", stall_cnt, 32'd5);
        chk("cnt5_w2_sat", {30'd0, stall_cnt2}, 32'd3);
        tick();
        rs_D = 5'd8; tuse_rs_D = 2'd0; a3_E = 5'd8; tnew_E = 2'd1;
        cnt_clr = 1'b1;
        tick();
        idle_inputs();
        #2;
        chk("clr_prio", stall_cnt, 32'd0);
        chk("clr_prio_w2", {30'd0, stall_cnt2}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
